// File: rtl/div_pkg.sv
// Shared constants and state encoding for the 12/6 sequential restoring divider.
package div_pkg;

  localparam int DW = 6;
  localparam int NW = 2 * DW;
  localparam int CW = $clog2(NW);
  localparam logic [CW-1:0] LAST_STEP = CW'(NW - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division step: shift in the next dividend bit,
// subtract the divisor when it fits and emit the resulting quotient bit.
module div_step
  import div_pkg::*;
(
  input  logic [DW:0]   r,
  input  logic          q_msb,
  input  logic [DW-1:0] divisor,
  output logic [DW:0]   r_next,
  output logic          q_bit
);

  logic [DW:0] shifted;
  logic [DW:0] diff;
  logic        take;

  // Trial subtraction at DW+1 bits, restore on borrow
  always_comb begin
    shifted = {r[DW-1:0], q_msb};
    diff    = shifted - {1'b0, divisor};
    // A set top bit means the shifted value already exceeds any DW-bit divisor
    take    = r[DW] | (shifted >= {1'b0, divisor});
    if (take) begin
      r_next = diff;
      q_bit  = 1'b1;
    end else begin
      r_next = shifted;
      q_bit  = 1'b0;
    end
  end

endmodule

// File: rtl/seq_div_12x6.sv
// Sequential restoring divider, 12-bit dividend by 6-bit divisor, one quotient bit per clock.
// Optional overflow flag port ovf is built when DIV_OVF_FLAG_EN is defined.
module seq_div_12x6
  import div_pkg::*;
(
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [NW-1:0] dividend,
  input  logic [DW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [NW-1:0] quotient,
  output logic [DW-1:0] remainder,
  output logic          dz
`ifdef DIV_OVF_FLAG_EN
  ,
  output logic          ovf
`endif
);

  state_t        state_r;
  logic [CW-1:0] cnt_r;
  logic [NW-1:0] q_r;
  logic [DW:0]   r_r;
  logic [DW-1:0] dvs_r;

  logic [DW:0]   r_next;
  logic          q_bit;
  logic [NW-1:0] q_next;

  div_step u_step (
    .r       (r_r),
    .q_msb   (q_r[NW-1]),
    .divisor (dvs_r),
    .r_next  (r_next),
    .q_bit   (q_bit)
  );

  assign q_next = {q_r[NW-2:0], q_bit};

  // Control FSM, datapath registers and registered result outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      q_r       <= {NW{1'b0}};
      r_r       <= {(DW+1){1'b0}};
      dvs_r     <= {DW{1'b0}};
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
      quotient  <= {NW{1'b0}};
      remainder <= {DW{1'b0}};
      dz        <= 1'b0;
`ifdef DIV_OVF_FLAG_EN
      ovf       <= 1'b0;
`endif
    end else begin
      case (state_r)
        IDLE: begin
          if (in_valid) begin
            dvs_r    <= divisor;
            q_r      <= dividend;
            r_r      <= {(DW+1){1'b0}};
            cnt_r    <= {CW{1'b0}};
            in_ready <= 1'b0;
            if (divisor == {DW{1'b0}}) begin
              state_r   <= DONE;
              out_valid <= 1'b1;
              quotient  <= {NW{1'b1}};
              remainder <= dividend[DW-1:0];
              dz        <= 1'b1;
`ifdef DIV_OVF_FLAG_EN
              ovf       <= 1'b1;
`endif
            end else begin
              state_r <= BUSY;
            end
          end else begin
            in_ready <= 1'b1;
          end
        end
        BUSY: begin
          q_r   <= q_next;
          r_r   <= r_next;
          cnt_r <= cnt_r + {{(CW-1){1'b0}}, 1'b1};
          if (cnt_r == LAST_STEP) begin
            state_r   <= DONE;
            out_valid <= 1'b1;
            quotient  <= q_next;
            remainder <= r_next[DW-1:0];
            dz        <= 1'b0;
`ifdef DIV_OVF_FLAG_EN
            ovf       <= |q_next[NW-1:DW];
`endif
          end else begin
            state_r <= BUSY;
          end
        end
        DONE: begin
          if (out_ready) begin
            state_r   <= IDLE;
            out_valid <= 1'b0;
            in_ready  <= 1'b1;
          end else begin
            state_r <= DONE;
          end
        end
        default: begin
          state_r   <= IDLE;
          out_valid <= 1'b0;
          in_ready  <= 1'b1;
        end
      endcase
    end
  end

endmodule
